// File: rtl/poly_eval_horner.sv
// poly_eval_horner
//   Captures a stream of npoints field coefficients, highest degree first.
//   It then evaluates the polynomial at a supplied point x by Horner's rule.
//   Each cycle performs one modular multiply-add. All arithmetic is mod `F_Q
//   on `F_NBITS-bit words.
//
// Ports
//   clk          rising-edge clock
//   rstb         asynchronous active-low reset
//   c_wren       coefficient write strobe (honoured only while idle)
//   c_data       coefficient word; k-th write is the coefficient of x^(npoints-1-k)
//   en           start-evaluation request (honoured when idle and loaded)
//   x            evaluation point, sampled with an accepted en
//   y            result, held until the next completion
//   ready        idle and able to accept en
//   ready_pulse  one-cycle completion strobe; y is valid in that cycle
//   loaded       exactly npoints coefficients are held

`ifndef F_NBITS
`define F_NBITS 64
`endif
`ifndef F_Q
`define F_Q 64'hFFFF_FFFF_0000_0001
`endif

module poly_eval_horner #(
  parameter int unsigned npoints = 9
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                c_wren,
  input  logic [`F_NBITS-1:0] c_data,
  input  logic                en,
  input  logic [`F_NBITS-1:0] x,
  output logic [`F_NBITS-1:0] y,
  output logic                ready,
  output logic                ready_pulse,
  output logic                loaded
);

  localparam int unsigned W   = `F_NBITS;
  localparam int unsigned PW  = (npoints > 1) ? $clog2(npoints) : 1;
  localparam logic [W-1:0]   Q     = W'(`F_Q);
  localparam logic [2*W-1:0] Q_WIDE = {{W{1'b0}}, Q};
  localparam logic [W:0]     Q_SUM  = {1'b0, Q};
  localparam logic [PW-1:0]  LAST   = PW'(npoints - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   coef_q [npoints];
  logic [W-1:0]   coef_d [npoints];
  logic [PW-1:0]  wp_q, wp_d;
  logic [PW-1:0]  idx_q, idx_d;
  logic           loaded_q, loaded_d;
  logic [W-1:0]   xr_q, xr_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   y_q, y_d;
  logic           ready_q, ready_d;
  logic           ready_pulse_q, ready_pulse_d;

  // Horner step datapath: full-width product reduced mod Q, then the add is
  // folded back into range with a single conditional subtract.
  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_red;
  logic [W:0]     sum;
  logic [W-1:0]   step;

  always_comb begin
    prod     = {{W{1'b0}}, acc_q} * {{W{1'b0}}, xr_q};
    prod_red = W'(prod % Q_WIDE);
    sum      = {1'b0, prod_red} + {1'b0, coef_q[idx_q]};
    step     = (sum >= Q_SUM) ? W'(sum - Q_SUM) : sum[W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    coef_d        = coef_q;
    wp_d          = wp_q;
    idx_d         = idx_q;
    loaded_d      = loaded_q;
    xr_d          = xr_q;
    acc_d         = acc_q;
    y_d           = y_q;
    ready_d       = ready_q;
    ready_pulse_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (c_wren) begin
          coef_d[wp_q] = c_data;
          if (wp_q == LAST) begin
            wp_d     = '0;
            loaded_d = 1'b1;
          end else begin
            wp_d = wp_q + PW'(1);
            // First word of a fresh polynomial invalidates the held one.
            if (loaded_q && (wp_q == '0)) begin
              loaded_d = 1'b0;
            end
          end
        end

        // en sees the pre-edge loaded flag and coef[0], even when a write
        // lands on the same edge.
        if (en && loaded_q) begin
          xr_d  = x;
          acc_d = coef_q[0];
          idx_d = PW'(1);
          if (npoints == 1) begin
            y_d           = coef_q[0];
            ready_d       = 1'b1;
            ready_pulse_d = 1'b1;
          end else begin
            ready_d = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d = step;
        idx_d = idx_q + PW'(1);
        if (idx_q == LAST) begin
          y_d           = step;
          ready_d       = 1'b1;
          ready_pulse_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= S_IDLE;
      wp_q          <= '0;
      idx_q         <= '0;
      loaded_q      <= 1'b0;
      xr_q          <= '0;
      acc_q         <= '0;
      y_q           <= '0;
      ready_q       <= 1'b1;
      ready_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      idx_q         <= idx_d;
      loaded_q      <= loaded_d;
      xr_q          <= xr_d;
      acc_q         <= acc_d;
      y_q           <= y_d;
      ready_q       <= ready_d;
      ready_pulse_q <= ready_pulse_d;
    end
  end

  // Coefficient storage needs no reset: it is only trusted while loaded is set.
  always_ff @(posedge clk) begin
    coef_q <= coef_d;
  end

  assign y           = y_q;
  assign ready       = ready_q;
  assign ready_pulse = ready_pulse_q;
  assign loaded      = loaded_q;

endmodule
